// File: rtl/apb_single_master.sv
// rtl/apb_single_master.sv - single-outstanding req/gnt to APB3 initiator
// One SETUP/ACCESS pair per request, response on a one-cycle rvalid_o strobe.
module apb_single_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // A zero TIMEOUT_CYCLES disables the abort; TO_LAST is then never compared.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic        timeout;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_o     = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rvalid_o  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) state_nxt = SETUP;
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          state_nxt = RESP;
        end else if (TO_EN && (wait_cnt == TO_LAST)) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rvalid_o  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      PADDR    <= '0;
      PWDATA   <= '0;
      PWRITE   <= 1'b0;
      wait_cnt <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            PADDR  <= addr_i;
            PWRITE <= we_i;
            PWDATA <= wdata_i;
          end
        end
        SETUP: wait_cnt <= '0;
        ACCESS: begin
          if (PREADY) begin
            rdata_o <= PWRITE ? 32'h0 : PRDATA;
            err_o   <= PSLVERR;
          end else if (timeout) begin
            rdata_o <= 32'h0;
            err_o   <= 1'b1;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_single_master.sv
// tb/tb_apb_single_master.sv - directed self-checking bench for apb_single_master
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_apb_single_master;

  logic        HCLK;
  logic        HRESET;
  logic        req_i;
  logic [11:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int passed = 0;
  int total  = 0;

  apb_single_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick(); #1;
    total++; if ({PSEL, PENABLE, PWRITE, rvalid_o, err_o} !== 5'b0)
      $display("FAIL rst_ctrl: got %b want 00000", {PSEL, PENABLE, PWRITE, rvalid_o, err_o}); else passed++;
    total++; if ({PADDR, PWDATA, rdata_o} !== 76'h0)
      $display("FAIL rst_data: got %h/%h/%h want 0/0/0", PADDR, PWDATA, rdata_o); else passed++;
    req_i = 1'b1; #1;
    total++; if (gnt_o !== 1'b1) $display("FAIL rst_gnt_follow: got %b want 1", gnt_o); else passed++;
    req_i = 1'b0;
    tick();
    HRESET = 1'b0;
  endtask

  task automatic test_write();
    tick();
    req_i = 1'b1; addr_i = 12'h004; we_i = 1'b1; wdata_i = 32'h12345678; #1;
    total++; if (gnt_o !== 1'b1) $display("FAIL wr_gnt: got %b want 1", gnt_o); else passed++;
    tick();
    req_i = 1'b0; addr_i = 12'hFFF; wdata_i = 32'h0; PREADY = 1'b1; PRDATA = 32'hDEADBEEF; #1;
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b101)
      $display("FAIL wr_setup: got %b want 101", {PSEL, PENABLE, PWRITE}); else passed++;
    total++; if (PADDR !== 12'h004 || PWDATA !== 32'h12345678)
      $display("FAIL wr_addr_data: got %h/%h want 004/12345678", PADDR, PWDATA); else passed++;
    tick(); #1;
    total++; if ({PSEL, PENABLE, rvalid_o} !== 3'b110)
      $display("FAIL wr_access: got %b want 110", {PSEL, PENABLE, rvalid_o}); else passed++;
    tick(); #1;
    total++; if ({rvalid_o, err_o, PSEL, PENABLE} !== 4'b1000)
      $display("FAIL wr_resp: got %b want 1000", {rvalid_o, err_o, PSEL, PENABLE}); else passed++;
    total++; if (rdata_o !== 32'h0) $display("FAIL wr_rdata: got %h want 00000000", rdata_o); else passed++;
    PREADY = 1'b0;
  endtask

  task automatic test_read_wait();
    tick();
    req_i = 1'b1; addr_i = 12'h004; we_i = 1'b0; #1;
    total++; if (gnt_o !== 1'b1) $display("FAIL rd_gnt: got %b want 1", gnt_o); else passed++;
    tick();
    req_i = 1'b0; addr_i = 12'h0; PREADY = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick(); #1;
      total++; if ({PSEL, PENABLE, rvalid_o} !== 3'b110 || PADDR !== 12'h004)
        $display("FAIL rd_wait_c%0d: got %b addr %h want 110 addr 004", c, {PSEL, PENABLE, rvalid_o}, PADDR);
      else passed++;
    end
    tick();
    PREADY = 1'b1; PRDATA = 32'h12345678; #1;
    total++; if (PENABLE !== 1'b1 || PADDR !== 12'h004)
      $display("FAIL rd_ready_cycle: got en %b addr %h want 1 004", PENABLE, PADDR); else passed++;
    tick();
    PREADY = 1'b0; PRDATA = 32'h0; #1;
    total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h12345678 || err_o !== 1'b0)
      $display("FAIL rd_resp_c6: got v%b %h e%b want v1 12345678 e0", rvalid_o, rdata_o, err_o); else passed++;
  endtask

  task automatic test_slverr();
    logic [31:0] dat [2];
    logic        se   [2];
    dat[0] = 32'hCAFE0001; se[0] = 1'b1;
    dat[1] = 32'h0000BEEF; se[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      req_i = 1'b1; addr_i = 12'h100; we_i = 1'b0;
      tick();
      req_i = 1'b0; PREADY = 1'b1; PSLVERR = se[i]; PRDATA = dat[i];
      tick();
      tick();
      PREADY = 1'b0; PSLVERR = 1'b0; #1;
      total++; if (rvalid_o !== 1'b1 || err_o !== se[i] || rdata_o !== dat[i])
        $display("FAIL slverr_%0d: got v%b e%b %h want v1 e%b %h", i, rvalid_o, err_o, rdata_o, se[i], dat[i]);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    int acc;
    int seen;
    tick();
    req_i = 1'b1; addr_i = 12'h010; we_i = 1'b0;
    tick();
    req_i = 1'b0; PREADY = 1'b0; PRDATA = 32'hFFFFFFFF; PSLVERR = 1'b1;
    acc = 0; seen = 0;
    for (int n = 0; n < 20; n++) begin
      tick(); #1;
      if (rvalid_o) begin
        seen = n + 2;
        break;
      end
      if (PENABLE) acc++;
    end
    total++; if (acc !== 4) $display("FAIL to_access_len: got %0d want 4", acc); else passed++;
    total++; if (seen !== 6) $display("FAIL to_rvalid_cycle: got %0d want 6", seen); else passed++;
    total++; if (err_o !== 1'b1 || rdata_o !== 32'h0 || PSEL !== 1'b0)
      $display("FAIL to_resp: got e%b %h sel%b want e1 00000000 sel0", err_o, rdata_o, PSEL); else passed++;
    tick();
    req_i = 1'b1; addr_i = 12'h014;
    tick();
    req_i = 1'b0;
    tick(); tick(); tick();
    tick();
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hA5A5A5A5;
    tick();
    PREADY = 1'b0; #1;
    total++; if (rvalid_o !== 1'b1 || err_o !== 1'b0 || rdata_o !== 32'hA5A5A5A5)
      $display("FAIL to_ready_wins: got v%b e%b %h want v1 e0 a5a5a5a5", rvalid_o, err_o, rdata_o); else passed++;
  endtask

  task automatic test_back_to_back();
    logic exp_g;
    logic exp_v;
    tick();
    req_i = 1'b1; addr_i = 12'h020; we_i = 1'b1; wdata_i = 32'h55AA55AA; PREADY = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 9) req_i = 1'b0;
      #1;
      exp_g = ((c % 4) == 0) && (c <= 8);
      exp_v = ((c % 4) == 3);
      total++; if (gnt_o !== exp_g || rvalid_o !== exp_v)
        $display("FAIL b2b_c%0d: got g%b v%b want g%b v%b", c, gnt_o, rvalid_o, exp_g, exp_v);
      else passed++;
      tick();
    end
    PREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_i = 1'b1; addr_i = 12'h030; we_i = 1'b0;
    tick();
    req_i = 1'b0; PREADY = 1'b0;
    tick(); #1;
    total++; if ({PSEL, PENABLE} !== 2'b11)
      $display("FAIL rstmid_pre: got %b want 11", {PSEL, PENABLE}); else passed++;
    HRESET = 1'b1; #1;
    total++; if ({PSEL, PENABLE, rvalid_o, err_o} !== 4'b0 || PADDR !== 12'h0)
      $display("FAIL rstmid_async: got %b addr %h want 0000 addr 000", {PSEL, PENABLE, rvalid_o, err_o}, PADDR);
    else passed++;
    tick();
    HRESET = 1'b0; PREADY = 1'b1; PRDATA = 32'h0BAD0BAD;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      total++; if (rvalid_o !== 1'b0 || PSEL !== 1'b0)
        $display("FAIL rstmid_quiet_%0d: got v%b sel%b want v0 sel0", c, rvalid_o, PSEL); else passed++;
    end
    req_i = 1'b1; addr_i = 12'h034; #1;
    total++; if (gnt_o !== 1'b1) $display("FAIL rstmid_regnt: got %b want 1", gnt_o); else passed++;
    tick();
    req_i = 1'b0;
    tick();
    tick(); #1;
    total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0BAD0BAD || err_o !== 1'b0)
      $display("FAIL rstmid_xfer: got v%b %h e%b want v1 0bad0bad e0", rvalid_o, rdata_o, err_o); else passed++;
    PREADY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
